overlap_add_ctrl: RTL and testbench
===================================

Name: overlap_add_ctrl

Overview:
- Sequences the AAC overlap/add stage for one channel.
- Accepts a stream of windowed IMDCT output words, two 16-bit PCM samples per 32-bit word, 2*HALF_WORDS words per frame.
- Holds the previous frame's second half in an internal history buffer, emits one half-window of PCM per frame, and applies the first/middle/last sequence-position rule.
- Sits between the windowing block and the PCM output interface.

Parameters:
- wordLength, 16, bits per PCM sample; each data word is 2*wordLength bits.
- HALF_WORDS, 256, words per half window (512 samples / 2).
- ADDR_W, 8, log2(HALF_WORDS).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse that opens a frame; sampled only in IDLE.
- seq_pos  input  2  captured with frame_start: 00 middle, 01 first, 10 last, 11 reserved.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid & in_ready.
- in_data  input  2*wordLength  lane0 [wordLength-1:0], lane1 upper.
- out_valid  output  1  PCM word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  2*wordLength  PCM word.
- busy  output  1  high from frame acceptance until frame_done.
- frame_done  output  1  one-cycle pulse after the last input word of a frame is accepted.
- err  output  1  one-cycle pulse on frame_start while busy, or on seq_pos=11.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, err=0, state=IDLE, hist_valid=0, word counter=0. History RAM contents are not reset; hist_valid gates their use.
- A reset mid-frame discards the frame. The next frame behaves as if it were the first after power-up.

State machine:
- IDLE: in_ready=0.
  - frame_start with seq_pos in {00,01,10}: capture seq_pos, set busy, go to HEAD, counter=0.
  - frame_start with seq_pos=11: pulse err, stay in IDLE.
  - in_valid is ignored in IDLE, including in the frame_start cycle.
- HEAD (words 0..HALF_WORDS-1):
  - in_ready = !out_valid | out_ready (single output register, no bubble under full throughput).
  - On accept, out_data is registered one cycle later and out_valid rises.
  - middle: per-lane out = in_lane + hist_lane[counter], modulo 2^wordLength, with no carry between lanes. If hist_valid=0, hist is treated as 0.
  - first: out = in_data.
  - last: out = hist[counter], or 0 if hist_valid=0. The input is consumed and discarded.
  - Counter wraps at HALF_WORDS-1, then go to TAIL.
- TAIL (words HALF_WORDS..2*HALF_WORDS-1):
  - in_ready=1 once the HEAD output register has drained or is draining (in_ready = !out_valid | out_ready). No output is generated.
  - Each accepted word is written to hist[counter]. For seq_pos=last, 0 is written instead.
  - On the final accept: pulse frame_done, clear busy, go to IDLE.
  - hist_valid is set to 1 for first/middle and cleared for last.
- History RAM: one read port, addressed in HEAD; one write port, used in TAIL. The read is combinational from the register array, so there are no read/write hazards within a frame.
- Latency: 1 cycle from input accept to out_valid in HEAD.
- out_valid holds with stable out_data until out_ready.
- frame_start while busy: pulse err, ignored; the frame in progress is unaffected.
- Simultaneous final TAIL accept and frame_start: frame_start is ignored with err, because busy is still high that cycle.
- Backpressure: in_valid may drop at any cycle; the counter advances only on accept.

Decomposition:
- Shared package overlap_pkg:
  - seq_pos encodings: SEQ_MIDDLE=2'b00, SEQ_FIRST=2'b01, SEQ_LAST=2'b10.
  - State encodings: IDLE, HEAD, TAIL.
  - wordLength and HALF_WINDOW_SIZE=512 constants.
- One sub-module, overlap_hist_buf: a HALF_WORDS x 2*wordLength register array with synchronous write and asynchronous read.

Test Plan:
- Reset, then a middle frame with hist_valid=0. HEAD words all 0x0003_0002 → 256 outputs equal 0x0003_0002. TAIL words 0x0010_0020 are stored; frame_done on the 512th accept.
- Following middle frame with HEAD words 0xFFFF_0001 → out = 0x000F_0021 per word. The lane1 wrap shows no carry into or out of the lane.
- first frame with HEAD 0x1234_5678 → out 0x1234_5678. Then a last frame → HEAD outputs equal the stored tail of the first frame, the frame's own input is ignored, and hist_valid=0 afterwards.
- out_ready toggled 1010... and in_valid randomly dropped → exactly 256 outputs in order, no duplicates, out_data stable while stalled.
- frame_start during TAIL → err pulse, frame completes normally. seq_pos=11 in IDLE → err, busy stays 0.
- Reset asserted at HEAD word 100 → all outputs at reset values immediately. Next middle frame with input 0x0001_0001 → out 0x0001_0001 (history ignored).

Source files
------------

// File: rtl/overlap_pkg.sv
// Shared types and constants for the AAC overlap/add controller.
package overlap_pkg;

    localparam int WORD_LENGTH      = 16;
    localparam int HALF_WINDOW_SIZE = 512;
    localparam int HALF_WORDS_DEF   = HALF_WINDOW_SIZE / 2;

    localparam logic [1:0] SEQ_MIDDLE = 2'b00;
    localparam logic [1:0] SEQ_FIRST  = 2'b01;
    localparam logic [1:0] SEQ_LAST   = 2'b10;
    localparam logic [1:0] SEQ_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        TAIL = 2'b10
    } state_t;

    function automatic logic seq_is_valid(input logic [1:0] s);
        return (s != SEQ_RSVD);
    endfunction

endpackage

// File: rtl/overlap_hist_buf.sv
// Half-window history store: synchronous write, combinational read, no reset.
module overlap_hist_buf #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Register-array write port; contents are qualified by hist_valid upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/overlap_add_ctrl.sv
// Overlap/add sequencer: adds HEAD words to the stored history, emits PCM, and
// stores the TAIL half for the next frame.
module overlap_add_ctrl
    import overlap_pkg::*;
#(
    parameter int wordLength = WORD_LENGTH,
    parameter int HALF_WORDS = HALF_WORDS_DEF,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic [1:0]              seq_pos,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*wordLength-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*wordLength-1:0] out_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err
);

    localparam int DW = 2 * wordLength;

    state_t            state;
    logic [1:0]        seq;
    logic [ADDR_W-1:0] cnt;
    logic              hist_valid;
    logic              accept;
    logic              last_word;
    logic              hist_wr_en;
    logic [DW-1:0]     hist_wr_data;
    logic [DW-1:0]     hist_rd_data;
    logic [DW-1:0]     hist_eff;
    logic [DW-1:0]     head_word;

    // A single output register: accept whenever it is empty or emptying this cycle.
    assign in_ready     = (state != IDLE) && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign last_word    = (cnt == ADDR_W'(HALF_WORDS - 1));
    assign hist_wr_en   = (state == TAIL) && accept;
    assign hist_wr_data = (seq == SEQ_LAST) ? {DW{1'b0}} : in_data;

    overlap_hist_buf #(
        .WIDTH  (DW),
        .DEPTH  (HALF_WORDS),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk     (clk),
        .wr_en   (hist_wr_en),
        .wr_addr (cnt),
        .wr_data (hist_wr_data),
        .rd_addr (cnt),
        .rd_data (hist_rd_data)
    );

    // HEAD output word per sequence position; lanes add independently, no carry.
    always_comb begin
        hist_eff  = hist_valid ? hist_rd_data : {DW{1'b0}};
        head_word = in_data;
        case (seq)
            SEQ_MIDDLE: begin
                for (int l = 0; l < 2; l++) begin
                    head_word[l*wordLength +: wordLength] =
                        in_data[l*wordLength +: wordLength] + hist_eff[l*wordLength +: wordLength];
                end
            end
            SEQ_FIRST: head_word = in_data;
            SEQ_LAST:  head_word = hist_eff;
            default:   head_word = in_data;
        endcase
    end

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            seq        <= SEQ_MIDDLE;
            cnt        <= {ADDR_W{1'b0}};
            hist_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= {DW{1'b0}};
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        if (seq_is_valid(seq_pos)) begin
                            seq   <= seq_pos;
                            busy  <= 1'b1;
                            cnt   <= {ADDR_W{1'b0}};
                            state <= HEAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                HEAD: begin
                    if (frame_start) begin
                        err <= 1'b1;
                    end
                    if (accept) begin
                        out_data  <= head_word;
                        out_valid <= 1'b1;
                        if (last_word) begin
                            cnt   <= {ADDR_W{1'b0}};
                            state <= TAIL;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (frame_start) begin
                        err <= 1'b1;
                    end
                    if (accept) begin
                        if (last_word) begin
                            cnt        <= {ADDR_W{1'b0}};
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            hist_valid <= (seq != SEQ_LAST);
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overlap_add_ctrl.sv
// Directed bench for overlap_add_ctrl: frame sequences with hand-computed PCM words.
module tb_overlap_add_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [1:0]  seq_pos = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic        frame_done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] act_q[$];
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = 32'h0;

    overlap_add_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .seq_pos     (seq_pos),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output monitor: collects transfers and checks that stalled data holds.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) act_q.push_back(out_data);
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic run_frame(input string tag, input logic [1:0] seq,
                             input logic [31:0] head_in, input logic [31:0] tail_in,
                             input logic [31:0] exp_head, input bit inc,
                             input bit toggle_rdy, input bit rand_vld,
                             input int fs_at, input int abort_at);
        int acc = 0;
        int cyc = 0;
        int nbad = 0;
        bit took;
        bit fs_now;
        bit fs_sent = 1'b0;
        act_q.delete();
        frame_start = 1'b1;
        seq_pos     = seq;
        in_valid    = 1'b1;
        in_data     = head_in;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (acc < 512 && cyc < 4000 && !(abort_at > 0 && acc == abort_at)) begin
            in_valid  = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = (acc < 256) ? head_in + (inc ? 32'(acc) : 32'd0) : tail_in;
            out_ready = toggle_rdy ? 1'(cyc % 2) : 1'b1;
            fs_now    = (fs_at > 0) && (acc >= fs_at) && !fs_sent;
            if (fs_now) fs_sent = 1'b1;
            frame_start = fs_now;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (fs_now) check({tag, "_err_busy"}, 32'(err), 32'd1);
            if (took) acc++;
            cyc++;
        end
        if (abort_at > 0 && acc == abort_at) return;
        check({tag, "_accepts"}, 32'(acc), 32'd512);
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        check({tag, "_nout"}, 32'(act_q.size()), 32'd256);
        for (int i = 0; i < act_q.size(); i++) begin
            if (act_q[i] !== exp_head + (inc ? 32'(i) : 32'd0)) nbad++;
        end
        check({tag, "_nbad"}, 32'(nbad), 32'd0);
        if (act_q.size() > 0) check({tag, "_word0"}, act_q[0], exp_head);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // middle with empty history, then middle adding the stored tail per lane
        run_frame("mid0", 2'b00, 32'h0003_0002, 32'h0010_0020, 32'h0003_0002, 1'b0, 1'b0, 1'b0, 0, 0);
        run_frame("mid1", 2'b00, 32'hFFFF_0001, 32'h0010_0020, 32'h000F_0021, 1'b0, 1'b0, 1'b0, 0, 0);
        run_frame("first", 2'b01, 32'h1234_5678, 32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0, 0);
        run_frame("last", 2'b10, 32'hDEAD_BEEF, 32'h7777_7777, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 0, 0);
        // history invalid after last: output equals input; backpressure on both sides
        run_frame("stall", 2'b00, 32'h0100_0000, 32'h0200_0300, 32'h0100_0000, 1'b1, 1'b1, 1'b1, 0, 0);
        run_frame("fs_tail", 2'b00, 32'h0001_0002, 32'h0010_0020, 32'h0201_0302, 1'b0, 1'b0, 1'b0, 300, 0);

        frame_start = 1'b1;
        seq_pos     = 2'b11;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("rsvd_err", 32'(err), 32'd1);
        check("rsvd_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rsvd_err_pulse", 32'(err), 32'd0);
        check("rsvd_busy2", 32'(busy), 32'd0);

        run_frame("abort", 2'b00, 32'h0005_0005, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 100);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame("post_rst", 2'b00, 32'h0001_0001, 32'h0, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
